// File: rtl/updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : updown_sweep_ctrl
//  Purpose  : Bounded up/down sweep counter. On an accepted start it counts
//             lo -> hi -> lo for a programmed number of sweeps, then pulses
//             done. Invalid starts are rejected with a one-cycle err pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module updown_sweep_ctrl #(
    parameter int WIDTH = 3,
    parameter int SWW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [SWW-1:0]   sweeps,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [SWW-1:0]   c_rem_one = SWW'(1);
    localparam logic [SWW-1:0]   c_rem_zero = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [SWW-1:0]   rem_q,     rem_d;
    logic             up_down_q, up_down_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    // Next-state and next-output computation; everything holds by default,
    // pulses (done/err) default low.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        rem_d     = rem_q;
        up_down_d = up_down_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d  = lo;
                    hi_d  = hi;
                    rem_d = sweeps;
                    if ((lo >= hi) || (sweeps == c_rem_zero)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = S_UP;
                        count_d   = lo;
                        up_down_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end

            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (count_q < hi_q) begin
                    count_d = count_q + c_one;
                end else begin
                    // Turn around: hi is shown for exactly one cycle.
                    state_d   = S_DOWN;
                    count_d   = hi_q - c_one;
                    up_down_d = 1'b0;
                end
            end

            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (count_q > lo_q) begin
                    count_d = count_q - c_one;
                end else if (rem_q == c_rem_one) begin
                    // Last sweep finished: park on lo and report completion.
                    state_d   = S_DONE;
                    rem_d     = c_rem_zero;
                    up_down_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    // lo was already shown this cycle, so restart at lo+1.
                    state_d   = S_UP;
                    rem_d     = rem_q - c_rem_one;
                    count_d   = lo_q + c_one;
                    up_down_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            rem_q     <= '0;
            up_down_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            rem_q     <= rem_d;
            up_down_q <= up_down_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign count   = count_q;
    assign up_down = up_down_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updown_sweep_ctrl
//  Purpose  : Directed self-checking bench for updown_sweep_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_updown_sweep_ctrl;

    localparam int WIDTH = 3;
    localparam int SWW   = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [SWW-1:0]   sweeps;
    logic [WIDTH-1:0] count;
    logic             up_down;
    logic             busy;
    logic             done;
    logic             err;

    int n_vec;
    int n_err;
    int busy_seen;

    updown_sweep_ctrl #(.WIDTH(WIDTH), .SWW(SWW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .lo      (lo),
        .hi      (hi),
        .sweeps  (sweeps),
        .count   (count),
        .up_down (up_down),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1ns later and check all outputs.
    // ud < 0 means direction is not checked for that cycle.
    task automatic cyc(input string tag, input int c, input int ud,
                       input bit b, input bit d, input bit e);
        @(posedge clk);
        #1;
        if (busy === 1'b1) busy_seen++;
        chk({tag, ".count"}, {29'd0, count}, c);
        if (ud >= 0) chk({tag, ".up_down"}, {31'd0, up_down}, ud);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
        chk({tag, ".err"},  {31'd0, err},  {31'd0, e});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        busy_seen = 0;
        clk = 1'b0;

        // Reset dominates simultaneous start/abort.
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        lo = 3'd3; hi = 3'd6; sweeps = 4'd2;
        cyc("RST0", 0, 1, 0, 0, 0);
        cyc("RST1", 0, 1, 0, 0, 0);

        // A: lo=2 hi=4 sweeps=1, start on first edge after reset release.
        rst = 1'b0; abort = 1'b0; start = 1'b1;
        lo = 3'd2; hi = 3'd4; sweeps = 4'd1;
        cyc("A0", 2, 1, 1, 0, 0);
        start = 1'b0; lo = 3'd7; hi = 3'd0; sweeps = 4'd0;
        cyc("A1", 3, 1, 1, 0, 0);
        cyc("A2", 4, 1, 1, 0, 0);
        cyc("A3", 3, 0, 1, 0, 0);
        cyc("A4", 2, 0, 1, 0, 0);
        cyc("A5", 2, 1, 0, 1, 0);
        start = 1'b1; lo = 3'd1; hi = 3'd3; sweeps = 4'd1;
        cyc("A6", 2, 1, 0, 0, 0);
        start = 1'b0;
        cyc("A7", 2, 1, 0, 0, 0);

        // B: full range, two sweeps, 29 busy cycles.
        lo = 3'd0; hi = 3'd7; sweeps = 4'd2; start = 1'b1;
        busy_seen = 0;
        for (int s = 0; s < 2; s++) begin
            for (int v = (s == 0) ? 0 : 1; v <= 7; v++) begin
                cyc("Bup", v, 1, 1, 0, 0);
                start = 1'b0;
            end
            for (int v = 6; v >= 0; v--) begin
                cyc("Bdn", v, 0, 1, 0, 0);
            end
        end
        chk("B.busy_cycles", busy_seen, 29);
        cyc("Bdone", 0, 1, 0, 1, 0);
        cyc("Bidle", 0, 1, 0, 0, 0);

        // C: rejected starts.
        lo = 3'd5; hi = 3'd5; sweeps = 4'd3; start = 1'b1;
        cyc("C0", 0, 1, 0, 0, 1);
        start = 1'b0;
        cyc("C1", 0, 1, 0, 0, 0);
        lo = 3'd1; hi = 3'd6; sweeps = 4'd0; start = 1'b1;
        cyc("C2", 0, 1, 0, 0, 1);
        start = 1'b0;
        cyc("C3", 0, 1, 0, 0, 0);
        lo = 3'd6; hi = 3'd2; sweeps = 4'd1; start = 1'b1;
        cyc("C4", 0, 1, 0, 0, 1);
        start = 1'b0;
        cyc("C5", 0, 1, 0, 0, 0);

        // D: abort in DOWN at count=4.
        lo = 3'd1; hi = 3'd6; sweeps = 4'd1; start = 1'b1;
        cyc("D0", 1, 1, 1, 0, 0);
        start = 1'b0;
        cyc("D1", 2, 1, 1, 0, 0);
        cyc("D2", 3, 1, 1, 0, 0);
        cyc("D3", 4, 1, 1, 0, 0);
        cyc("D4", 5, 1, 1, 0, 0);
        cyc("D5", 6, 1, 1, 0, 0);
        cyc("D6", 5, 0, 1, 0, 0);
        cyc("D7", 4, 0, 1, 0, 0);
        abort = 1'b1;
        cyc("D8", 4, -1, 0, 0, 0);
        abort = 1'b0;
        cyc("D9", 4, -1, 0, 0, 0);
        abort = 1'b1;
        cyc("D10", 4, -1, 0, 0, 0);
        abort = 1'b0;
        cyc("D11", 4, -1, 0, 0, 0);

        // G: abort beats turn-around at count==hi.
        lo = 3'd0; hi = 3'd2; sweeps = 4'd1; start = 1'b1;
        cyc("G0", 0, 1, 1, 0, 0);
        start = 1'b0;
        cyc("G1", 1, 1, 1, 0, 0);
        cyc("G2", 2, 1, 1, 0, 0);
        abort = 1'b1;
        cyc("G3", 2, -1, 0, 0, 0);
        abort = 1'b0;

        // H: abort beats sweep completion at count==lo.
        lo = 3'd0; hi = 3'd1; sweeps = 4'd1; start = 1'b1;
        cyc("H0", 0, 1, 1, 0, 0);
        start = 1'b0;
        cyc("H1", 1, 1, 1, 0, 0);
        cyc("H2", 0, 0, 1, 0, 0);
        abort = 1'b1;
        cyc("H3", 0, -1, 0, 0, 0);
        abort = 1'b0;
        cyc("H4", 0, -1, 0, 0, 0);

        // E: start ignored while busy, then reset mid-sequence.
        lo = 3'd0; hi = 3'd3; sweeps = 4'd3; start = 1'b1;
        cyc("E0", 0, 1, 1, 0, 0);
        start = 1'b0;
        cyc("E1", 1, 1, 1, 0, 0);
        start = 1'b1; lo = 3'd6; hi = 3'd7; sweeps = 4'd1;
        cyc("E2", 2, 1, 1, 0, 0);
        start = 1'b0;
        cyc("E3", 3, 1, 1, 0, 0);
        cyc("E4", 2, 0, 1, 0, 0);
        cyc("E5", 1, 0, 1, 0, 0);
        cyc("E6", 0, 0, 1, 0, 0);
        cyc("E7", 1, 1, 1, 0, 0);
        cyc("E8", 2, 1, 1, 0, 0);
        rst = 1'b1;
        cyc("E9", 0, 1, 0, 0, 0);
        rst = 1'b0;
        cyc("E10", 0, 1, 0, 0, 0);

        // F: single-step range, two sweeps.
        lo = 3'd3; hi = 3'd4; sweeps = 4'd2; start = 1'b1;
        cyc("F0", 3, 1, 1, 0, 0);
        start = 1'b0;
        cyc("F1", 4, 1, 1, 0, 0);
        cyc("F2", 3, 0, 1, 0, 0);
        cyc("F3", 4, 1, 1, 0, 0);
        cyc("F4", 3, 0, 1, 0, 0);
        cyc("F5", 3, 1, 0, 1, 0);
        cyc("F6", 3, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_sweep_ctrl.md
UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 Parameter: WIDTH, 3, counter and bound width in bits.
REQ-002 Parameter: SWW, 4, sweep-count width in bits.
REQ-003 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a sweep sequence.
REQ-006 abort  input  1  terminates a running sequence.
REQ-007 lo  input  WIDTH  lower bound, sampled on an accepted start.
REQ-008 hi  input  WIDTH  upper bound, sampled on an accepted start.
REQ-009 sweeps  input  SWW  number of lo->hi->lo sweeps, sampled on an accepted start.
REQ-010 count  output  WIDTH  registered counter value.
REQ-011 up_down  output  1  current direction: 1 = up, 0 = down.
REQ-012 busy  output  1  high in UP or DOWN.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-015 The block SHALL implement the states IDLE, UP, DOWN and DONE, with all outputs registered.
REQ-016 In IDLE, start=1 SHALL be accepted and SHALL latch lo, hi and sweeps.
REQ-017 An accepted start with lo>=hi or sweeps==0 SHALL pulse err for exactly the next cycle, stay in IDLE and leave count unchanged.
REQ-018 A valid accepted start SHALL set count=lo, up_down=1 and state UP on the next edge; busy SHALL rise in that same cycle.
REQ-019 In UP with count<hi: count SHALL be incremented by 1 per cycle.
REQ-020 In UP with count==hi: the block SHALL set count=hi-1, up_down=0 and state DOWN; the hi value SHALL be held for exactly one cycle.
REQ-021 In DOWN with count>lo: count SHALL be decremented by 1 per cycle.
REQ-022 In DOWN with count==lo, the block SHALL complete one sweep and decrement the remaining-sweep counter.
REQ-023 If that completed sweep was the last one: state SHALL become DONE, count SHALL hold lo, and up_down SHALL become 1.
REQ-024 Otherwise: count SHALL become lo+1, up_down SHALL become 1 and state SHALL return to UP.
REQ-025 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE.
REQ-026 In IDLE and DONE, count SHALL hold its last value.
REQ-027 count SHALL never leave [lo,hi] while busy, and SHALL never wrap modulo 2^WIDTH.
REQ-028 start while busy or in DONE SHALL be ignored; it SHALL NOT be queued.
REQ-029 abort in UP or DOWN SHALL force IDLE on the next edge, freeze count, drop busy and produce no done pulse.
REQ-030 abort SHALL take priority over a same-cycle bound turn-around or sweep completion.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 After an accepted start, changes on lo, hi or sweeps SHALL have no effect until the next accepted start.
REQ-033 A single-step range (hi==lo+1) SHALL alternate lo, hi, lo with no stalled cycles.
REQ-034 Latency per sweep SHALL be 2*(hi-lo) cycles; a full valid sequence SHALL take 1 + sweeps*2*(hi-lo) cycles in UP/DOWN, plus one DONE cycle.

Reset
REQ-035 rst=1 at a clock edge SHALL force IDLE, count=0, up_down=1, busy=0, done=0, err=0 and remaining sweeps=0.
REQ-036 rst SHALL override start and abort in the same cycle.
REQ-037 rst asserted mid-sequence SHALL discard the sequence with no done pulse.
REQ-038 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-039 Start with lo=2, hi=4, sweeps=1 -> count 2,3,4,3,2 (busy=1, up_down 1,1,1,0,0), then done=1 for one cycle with count=2, then IDLE.
REQ-040 Start with lo=0, hi=7, sweeps=2 -> count 0..7..0..7..0 in 29 busy cycles, with no wrap past 7 or below 0.
REQ-041 Start with lo=5, hi=5, sweeps=3 -> err=1 for one cycle, busy stays 0, count unchanged; same result for lo=1, hi=6, sweeps=0.
REQ-042 Start with lo=1, hi=6; assert abort when count=4 in DOWN -> next cycle IDLE with count=4, busy=0, and done never asserted.
REQ-043 Start with lo=0, hi=3; pulse start again with lo=6 mid-run -> ignored, sweep stays within 0..3; rst when count=2 -> count=0, up_down=1, busy=0 on the next edge.
REQ-044 Start with lo=3, hi=4, sweeps=2 -> count 3,4,3,4,3, then done.
